// File: rtl/conv_complex_streamer.sv
// Captures a parallel complex convolution frame on conv_done and streams it out
// one complex sample per valid/ready transfer, flagging frames lost while busy.
module conv_complex_streamer #(
   parameter  int QI        = 4,
   parameter  int QF        = 4,
   parameter  int NUM_ELEMS = 3,
   localparam int W         = QI + QF,
   localparam int NOUT      = NUM_ELEMS + 2,
   localparam int IW        = (NOUT > 1) ? $clog2(NOUT) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2*W*NOUT-1:0]   conv,
   input  logic                  conv_ovf,
   input  logic                  conv_done,
   output logic                  busy,
   output logic [W-1:0]          out_re,
   output logic [W-1:0]          out_im,
   output logic [IW-1:0]         out_idx,
   output logic                  out_last,
   output logic                  out_ovf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  drop
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NOUT - 1);

   state_t                       state_q, state_d;
   logic [NOUT-1:0][2*W-1:0]     frame_q, frame_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic                         ovf_q, ovf_d;
   logic                         drop_q, drop_d;
   logic                         xfer, at_last;

   assign at_last = (idx_q == LAST_IDX);
   assign xfer    = (state_q == SEND) && out_ready;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE: begin
            if (conv_done) begin
               frame_d = conv;
               ovf_d   = conv_ovf;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer && at_last) begin
               idx_d = '0;
               // A done coinciding with the final handshake starts the next frame seamlessly.
               if (conv_done) begin
                  frame_d = conv;
                  ovf_d   = conv_ovf;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) idx_d = idx_q + IW'(1);
               if (conv_done) drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         frame_q <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign busy      = (state_q == SEND);
   assign out_valid = (state_q == SEND);
   assign out_re    = frame_q[idx_q][2*W-1:W];
   assign out_im    = frame_q[idx_q][W-1:0];
   assign out_idx   = idx_q;
   assign out_last  = (state_q == SEND) && at_last;
   assign out_ovf   = ovf_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_conv_complex_streamer.sv
// Scoreboard bench for conv_complex_streamer: expected samples queued at stimulus,
// compared at every valid cycle and popped on each handshake.
module tb_conv_complex_streamer;
   localparam int W    = 8;
   localparam int NOUT = 5;
   localparam int IW   = 3;
   localparam int SW   = 2*W + IW + 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [2*W*NOUT-1:0]  conv = '0;
   logic                 conv_ovf = 1'b0;
   logic                 conv_done = 1'b0;
   logic                 busy, out_last, out_ovf, out_valid, drop;
   logic                 out_ready = 1'b1;
   logic [W-1:0]         out_re, out_im;
   logic [IW-1:0]        out_idx;

   int tests = 0;
   int fails = 0;
   int xfers = 0;
   logic [SW-1:0] sb[$];

   conv_complex_streamer #(.QI(4), .QF(4), .NUM_ELEMS(3)) dut (
      .clk(clk), .rst(rst), .conv(conv), .conv_ovf(conv_ovf), .conv_done(conv_done),
      .busy(busy), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
      .out_last(out_last), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W*NOUT-1:0] mk(input logic [W-1:0] re0, input logic [W-1:0] im0,
                                               input int dre, input int dim);
      logic [2*W*NOUT-1:0] f = '0;
      for (int k = 0; k < NOUT; k++) begin
         f[2*W*k +: 2*W] = {W'(re0 + k*dre), W'(im0 + k*dim)};
      end
      return f;
   endfunction

   task automatic push_frame(input logic [2*W*NOUT-1:0] f, input logic ovf);
      for (int k = 0; k < NOUT; k++) begin
         sb.push_back({f[2*W*k +: 2*W], IW'(k), (k == NOUT-1), ovf});
      end
   endtask

   // Called just after a rising edge; returns just after the capture edge.
   task automatic pulse(input logic [2*W*NOUT-1:0] f, input logic ovf, input bit expect_cap);
      conv = f; conv_ovf = ovf; conv_done = 1'b1;
      if (expect_cap) push_frame(f, ovf);
      @(posedge clk); #1;
      conv_done = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(tag, {busy, sb.size() == 0}, 2'b01);
   endtask

   // Scoreboard monitor: whatever is valid must equal the head of the queue.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            check("sample", {out_re, out_im, out_idx, out_last, out_ovf}, sb[0]);
            if (out_ready) begin
               void'(sb.pop_front());
               xfers++;
            end
         end
      end
   end

   initial begin
      logic [2*W*NOUT-1:0] f;
      logic [11:0] pat;
      int x0;

      // Reset state
      repeat (2) @(posedge clk); #1;
      check("rst_outs", {busy, out_valid, out_last, out_ovf, drop}, 0);
      check("rst_data", {out_re, out_im, out_idx}, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_valid", out_valid, 0);

      // Full frame, ready held high: 5 beats, no bubbles
      out_ready = 1'b1;
      pulse(mk(8'h10, 8'hF0, 1, -1), 1'b1, 1);
      @(negedge clk);
      check("latency_valid", out_valid, 1);
      check("busy_send", busy, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("beat5_last", {out_valid, out_last, out_idx}, {1'b1, 1'b1, 3'd4});
      @(posedge clk);
      @(negedge clk);
      check("frameA_done", {out_valid, busy, sb.size() == 0}, 3'b001);

      // Backpressure
      @(posedge clk); #1;
      x0 = xfers;
      pulse(mk(8'h20, 8'h05, 3, 7), 1'b0, 1);
      pat = 12'b100101101101;
      for (int i = 11; i >= 0; i--) begin
         out_ready = pat[i];
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_xfers", xfers - x0, 5);
      check("bp_busy_low", busy, 0);

      // Back-to-back: second done lands on the final handshake
      @(posedge clk); #1;
      pulse(mk(8'h31, 8'h42, 2, 1), 1'b1, 1);
      repeat (4) @(posedge clk); #1;
      f = mk(8'h04, 8'h20, 5, -3);
      pulse(f, 1'b0, 1);
      @(negedge clk);
      check("b2b_head", {out_valid, out_idx, out_re, out_im}, {1'b1, 3'd0, 8'h04, 8'h20});
      check("b2b_nodrop", drop, 0);
      wait_idle("b2b_idle");
      check("b2b_drop_final", drop, 0);

      // Drop while mid-frame; frame carries extreme values on the last sample
      @(posedge clk); #1;
      f = mk(8'h50, 8'h60, 1, 1);
      f[2*W*4 +: 2*W] = {8'h80, 8'h7F};
      pulse(f, 1'b1, 1);
      @(posedge clk); #1;
      pulse(mk(8'hAA, 8'hBB, 1, 1), 1'b0, 0);
      @(negedge clk);
      check("drop_set", drop, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("edge_last", {out_re, out_im, out_last}, {8'h80, 8'h7F, 1'b1});
      wait_idle("drop_idle");
      check("drop_sticky", drop, 1);

      // Reset mid-frame at idx 2 abandons the frame
      @(posedge clk); #1;
      pulse(mk(8'h01, 8'h02, 1, 1), 1'b1, 1);
      repeat (2) @(posedge clk); #1;
      check("pre_rst_idx", out_idx, 2);
      rst = 1'b0;
      #1;
      check("mid_rst_outs", {busy, out_valid, out_last, out_ovf, drop}, 0);
      check("mid_rst_data", {out_re, out_im, out_idx}, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_quiet", out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
